// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// Execution unit for the 4-bit ALU control code. Logical ops (AND/OR/XOR)
// finish in the accept cycle. ADD/SUB run through a single CHUNK-wide adder
// slice, one slice per clock, to keep the adder small. Results are returned
// on a valid/ready channel with zero and illegal-op flags.
//
// State table:
//   IDLE | waiting for a request, req_ready high
//   CALC | chunk-serial ADD/SUB in progress
//   DONE | response held on rsp_* until rsp_ready
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   req_valid/ready   request handshake
//   req_ctrl          op code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1100 XOR
//   req_a, req_b      operands (XLEN)
//   rsp_valid/ready   response handshake
//   rsp_result        result (XLEN)
//   rsp_zero          result == 0, forced low on illegal op
//   rsp_err           illegal op code
//   busy              state != IDLE
//
// CHUNK must divide XLEN exactly; N = XLEN/CHUNK slices.
// ----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_ctrl,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err,
    output logic            busy
);

    localparam int N  = XLEN / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_carry;
    logic [CW-1:0]   r_count;
    logic            r_zero;
    logic            r_err;

    logic            w_idle;
    logic            w_accept;
    logic            w_is_sub;
    logic            w_is_arith;
    logic            w_is_logic;
    logic [XLEN-1:0] w_b_eff;
    logic [XLEN-1:0] w_logic_res;
    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_src_b;
    logic            w_cin;
    logic [CW-1:0]   w_idx;
    int              w_base;
    logic [CHUNK:0]  w_sum_ext;
    logic [XLEN-1:0] w_result_next;
    logic            w_last;

    assign w_idle     = (r_state == IDLE);
    assign w_accept   = req_valid && w_idle;
    assign w_is_sub   = (req_ctrl == OP_SUB);
    assign w_is_arith = (req_ctrl == OP_ADD) || w_is_sub;
    assign w_is_logic = (req_ctrl == OP_AND) || (req_ctrl == OP_OR) || (req_ctrl == OP_XOR);
    assign w_b_eff    = w_is_sub ? ~req_b : req_b;

    always_comb begin
        w_logic_res = '0;
        case (req_ctrl)
            OP_AND:  w_logic_res = req_a & req_b;
            OP_OR:   w_logic_res = req_a | req_b;
            OP_XOR:  w_logic_res = req_a ^ req_b;
            default: w_logic_res = '0;
        endcase
    end

    // The accept cycle already feeds chunk 0 of the live request operands
    // through the adder slice, so CALC only has to cover chunks 1..N-1.
    // That gives N cycles from accept to rsp_valid, and N == 1 skips CALC.
    assign w_src_a = w_idle ? req_a    : r_a;
    assign w_src_b = w_idle ? w_b_eff  : r_b;
    assign w_cin   = w_idle ? w_is_sub : r_carry;
    assign w_idx   = w_idle ? '0       : r_count;
    assign w_last  = w_idle ? (N == 1) : (r_count == CW'(N - 1));

    always_comb begin
        w_base        = int'(w_idx) * CHUNK;
        w_sum_ext     = {1'b0, w_src_a[w_base +: CHUNK]}
                      + {1'b0, w_src_b[w_base +: CHUNK]}
                      + {{CHUNK{1'b0}}, w_cin};
        w_result_next = w_idle ? '0 : r_result;
        w_result_next[w_base +: CHUNK] = w_sum_ext[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_arith && !w_last) begin
                        w_state_next = CALC;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a;
                        r_b     <= w_b_eff;
                        r_err   <= !(w_is_arith || w_is_logic);
                        r_carry <= 1'b0;
                        r_count <= '0;
                        if (w_is_arith) begin
                            r_result <= w_result_next;
                            r_carry  <= w_sum_ext[CHUNK];
                            r_count  <= CW'(1);
                            r_zero   <= w_last && (w_result_next == '0);
                        end else if (w_is_logic) begin
                            r_result <= w_logic_res;
                            r_zero   <= (w_logic_res == '0);
                        end else begin
                            r_result <= '0;
                            r_zero   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_result <= w_result_next;
                    r_carry  <= w_sum_ext[CHUNK];
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        r_zero <= (w_result_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = w_idle;
    assign rsp_valid  = (r_state == DONE);
    assign busy       = !w_idle;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed-vector bench for alu_exec_unit (XLEN 32, CHUNK 8). Inputs change
// on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ctrl;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(.XLEN(32), .CHUNK(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ctrl   (req_ctrl),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present a request at a falling edge; it is accepted on the next rising edge.
    task automatic send(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_ctrl  = ctrl;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_ctrl  = 4'b1010;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h1234_5678;
    endtask

    // Count falling edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (rsp_valid) break;
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_idle_after"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                         input logic exp_z, input logic exp_e);
        send(ctrl, a, b);
        wait_rsp(tag, exp_lat);
        chk({tag, "_res"},  rsp_result, exp_res);
        chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_z});
        chk({tag, "_err"},  {31'd0, rsp_err},  {31'd0, exp_e});
        take_rsp(tag);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_ctrl  = 4'b0000;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_res",   rsp_result,         32'd0);
        chk("rst_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("add_carry", 4'b0010, 32'h0000_00FF, 32'h0000_0001, 4, 32'h0000_0100, 1'b0, 1'b0);
        do_op("sub_eq",    4'b0110, 32'd5,         32'd5,         4, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sub_neg",   4'b0110, 32'd0,         32'd1,         4, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("xor",       4'b1100, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F, 1'b0, 1'b0);
        do_op("and",       4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'h0F0F_0000, 1'b0, 1'b0);
        do_op("or",        4'b0001, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hFFFF_0F0F, 1'b0, 1'b0);
        do_op("and_zero",  4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 32'h0000_0000, 1'b1, 1'b0);
        do_op("add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 4, 32'h0000_0000, 1'b1, 1'b0);
        do_op("add_mid",   4'b0010, 32'h1234_5678, 32'h0FED_CBA9, 4, 32'h2222_2221, 1'b0, 1'b0);
        do_op("sub_big",   4'b0110, 32'h8000_0000, 32'h0000_0001, 4, 32'h7FFF_FFFF, 1'b0, 1'b0);
        do_op("ill_f",     4'b1111, 32'd0,         32'd0,         1, 32'h0000_0000, 1'b0, 1'b1);
        do_op("ill_3",     4'b0011, 32'h0000_0007, 32'h0000_0009, 1, 32'h0000_0000, 1'b0, 1'b1);

        // Backpressure: hold DONE while a different request waits on the input.
        send(4'b0001, 32'h0000_0001, 32'h0000_0002);
        wait_rsp("bp", 1);
        req_valid = 1'b1;
        req_ctrl  = 4'b0010;
        req_a     = 32'd3;
        req_b     = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_res",   rsp_result,         32'h0000_0003);
            chk("bp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 32'hFFFF_FFFF;
        wait_rsp("bp_pend", 4);
        chk("bp_pend_res", rsp_result, 32'd7);
        take_rsp("bp_pend");

        // Reset during the second CALC cycle aborts the op immediately.
        send(4'b0010, 32'h0000_0010, 32'h0000_0020);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_busy",  {31'd0, busy},      32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_res",   rsp_result,         32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        do_op("post_rst_add", 4'b0010, 32'd3, 32'd4, 4, 32'd7, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
